// File: rtl/soc_bus_pkg.sv
// soc_bus_pkg: shared types and default address map for the data bus demux.
//   target_e  - response-tracking target ID (RAM / PERI / ERR), 2 bits
//   bus_req_t - core request payload forwarded unchanged to every target
//   DEF_*     - default region base/mask constants
package soc_bus_pkg;

  typedef enum logic [1:0] {
    TGT_RAM  = 2'd0,
    TGT_PERI = 2'd1,
    TGT_ERR  = 2'd2
  } target_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_req_t;

  localparam logic [31:0] DEF_RAM_BASE  = 32'h0000_0000;
  localparam logic [31:0] DEF_RAM_MASK  = 32'hFFF0_0000;
  localparam logic [31:0] DEF_PERI_BASE = 32'h1A10_0000;
  localparam logic [31:0] DEF_PERI_MASK = 32'hFFF0_0000;

endpackage

// File: rtl/bus_resp_fifo.sv
// bus_resp_fifo: small FIFO tracking the target of every outstanding request.
//   clk, rst_n  - clock, async active-low reset (empties the FIFO)
//   push, din   - write din at the tail (ignored when full)
//   pop         - drop the head entry (ignored when empty)
//   full, empty - derived from the registered occupancy
//   head        - oldest entry (valid when !empty)
//   tail        - most recently pushed entry (valid when !empty)
module bus_resp_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head,
  output logic [W-1:0] tail
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic [CW-1:0]           cnt;
  logic                    do_push, do_pop;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      tail   <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= nxt(wr_ptr);
        tail        <= din;
      end
      if (do_pop) rd_ptr <= nxt(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/data_bus_demux.sv
// data_bus_demux: routes one core data port to a RAM or peripheral target by
// address, answers unmapped addresses with an error response, and returns
// responses in request order using a target-tracking FIFO.
//   clk, rst_n          - clock, async active-low reset
//   core_*              - core request / grant / response
//   ram_*               - RAM target request and handshake
//   peri_*              - peripheral target request and handshake
//   order_err_o         - sticky: a response arrived that did not match the head
// MAX_OUTST must be in 1..4.
module data_bus_demux
  import soc_bus_pkg::*;
#(
  parameter logic [31:0] RAM_BASE  = DEF_RAM_BASE,
  parameter logic [31:0] RAM_MASK  = DEF_RAM_MASK,
  parameter logic [31:0] PERI_BASE = DEF_PERI_BASE,
  parameter logic [31:0] PERI_MASK = DEF_PERI_MASK,
  parameter int          MAX_OUTST = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        core_req_i,
  input  logic [31:0] core_addr_i,
  input  logic        core_we_i,
  input  logic [3:0]  core_be_i,
  input  logic [31:0] core_wdata_i,
  output logic        core_gnt_o,
  output logic        core_rvalid_o,
  output logic [31:0] core_rdata_o,
  output logic        core_err_o,
  output logic        ram_req_o,
  output logic [31:0] ram_addr_o,
  output logic        ram_we_o,
  output logic [3:0]  ram_be_o,
  output logic [31:0] ram_wdata_o,
  input  logic        ram_gnt_i,
  input  logic        ram_rvalid_i,
  input  logic [31:0] ram_rdata_i,
  output logic        peri_req_o,
  output logic [31:0] peri_addr_o,
  output logic        peri_write_o,
  output logic [3:0]  peri_be_o,
  output logic [31:0] peri_wdata_o,
  input  logic        peri_gnt_i,
  input  logic        peri_rvalid_i,
  input  logic [31:0] peri_rdata_i,
  output logic        order_err_o
);

  bus_req_t   req;
  target_e    tgt, head_tgt, tail_tgt;
  logic [1:0] tgt_bits, head_bits, tail_bits;
  logic       fifo_full, fifo_empty, blocked, fwd, pop;

  // Request payload fans out to both targets untouched.
  assign req          = '{addr: core_addr_i, we: core_we_i, be: core_be_i, wdata: core_wdata_i};
  assign ram_addr_o   = req.addr;
  assign ram_we_o     = req.we;
  assign ram_be_o     = req.be;
  assign ram_wdata_o  = req.wdata;
  assign peri_addr_o  = req.addr;
  assign peri_write_o = req.we;
  assign peri_be_o    = req.be;
  assign peri_wdata_o = req.wdata;

  always_comb begin
    if ((core_addr_i & RAM_MASK) == RAM_BASE)        tgt = TGT_RAM;
    else if ((core_addr_i & PERI_MASK) == PERI_BASE) tgt = TGT_PERI;
    else                                             tgt = TGT_ERR;
  end

  assign tgt_bits = tgt;
  assign head_tgt = target_e'(head_bits);
  assign tail_tgt = target_e'(tail_bits);

  // Only one target may own the outstanding set at a time, so responses from
  // different targets can never reorder. Full uses registered occupancy, so a
  // same-cycle pop does not free a slot early.
  assign blocked = fifo_full | (~fifo_empty & (tail_tgt != tgt));
  // Outputs are forced low while reset is held, even with core_req_i high.
  assign fwd     = rst_n & core_req_i & ~blocked;

  assign ram_req_o  = fwd & (tgt == TGT_RAM);
  assign peri_req_o = fwd & (tgt == TGT_PERI);

  always_comb begin
    core_gnt_o = 1'b0;
    if (fwd) begin
      case (tgt)
        TGT_RAM:  core_gnt_o = ram_gnt_i;
        TGT_PERI: core_gnt_o = peri_gnt_i;
        default:  core_gnt_o = 1'b1;
      endcase
    end
  end

  // Response steering by FIFO head. An ERR head answers immediately.
  always_comb begin
    core_rvalid_o = 1'b0;
    core_rdata_o  = 32'h0;
    core_err_o    = 1'b0;
    if (rst_n && !fifo_empty) begin
      case (head_tgt)
        TGT_RAM: begin
          core_rvalid_o = ram_rvalid_i;
          core_rdata_o  = ram_rvalid_i ? ram_rdata_i : 32'h0;
        end
        TGT_PERI: begin
          core_rvalid_o = peri_rvalid_i;
          core_rdata_o  = peri_rvalid_i ? peri_rdata_i : 32'h0;
        end
        default: begin
          core_rvalid_o = 1'b1;
          core_err_o    = 1'b1;
        end
      endcase
    end
  end

  assign pop = core_rvalid_o;

  bus_resp_fifo #(
    .DEPTH (MAX_OUTST),
    .W     (2)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (core_gnt_o),
    .din   (tgt_bits),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head_bits),
    .tail  (tail_bits)
  );

  // A target response that is not owed to the head is dropped and flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      order_err_o <= 1'b0;
    end else if ((ram_rvalid_i  && (fifo_empty || head_tgt != TGT_RAM)) ||
                 (peri_rvalid_i && (fifo_empty || head_tgt != TGT_PERI))) begin
      order_err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_data_bus_demux.sv
module tb_data_bus_demux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_req_i;
  logic [31:0] core_addr_i;
  logic        core_we_i;
  logic [3:0]  core_be_i;
  logic [31:0] core_wdata_i;
  logic        core_gnt_o, core_rvalid_o, core_err_o;
  logic [31:0] core_rdata_o;
  logic        ram_req_o, ram_we_o;
  logic [31:0] ram_addr_o, ram_wdata_o;
  logic [3:0]  ram_be_o;
  logic        ram_gnt_i, ram_rvalid_i;
  logic [31:0] ram_rdata_i;
  logic        peri_req_o, peri_write_o;
  logic [31:0] peri_addr_o, peri_wdata_o;
  logic [3:0]  peri_be_o;
  logic        peri_gnt_i, peri_rvalid_i;
  logic [31:0] peri_rdata_i;
  logic        order_err_o;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  data_bus_demux dut (
    .clk(clk), .rst_n(rst_n),
    .core_req_i(core_req_i), .core_addr_i(core_addr_i), .core_we_i(core_we_i),
    .core_be_i(core_be_i), .core_wdata_i(core_wdata_i),
    .core_gnt_o(core_gnt_o), .core_rvalid_o(core_rvalid_o),
    .core_rdata_o(core_rdata_o), .core_err_o(core_err_o),
    .ram_req_o(ram_req_o), .ram_addr_o(ram_addr_o), .ram_we_o(ram_we_o),
    .ram_be_o(ram_be_o), .ram_wdata_o(ram_wdata_o),
    .ram_gnt_i(ram_gnt_i), .ram_rvalid_i(ram_rvalid_i), .ram_rdata_i(ram_rdata_i),
    .peri_req_o(peri_req_o), .peri_addr_o(peri_addr_o), .peri_write_o(peri_write_o),
    .peri_be_o(peri_be_o), .peri_wdata_o(peri_wdata_o),
    .peri_gnt_i(peri_gnt_i), .peri_rvalid_i(peri_rvalid_i), .peri_rdata_i(peri_rdata_i),
    .order_err_o(order_err_o)
  );

  // Response scoreboard: every core response must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      n_cmp++;
      if (core_rvalid_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL resp_unexpected: rvalid=1 rdata=%h err=%b, required no response",
                   core_rdata_o, core_err_o);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (core_rdata_o !== e.data || core_err_o !== e.err) begin
            n_bad++;
            $display("FAIL resp_data: rdata=%h err=%b, required rdata=%h err=%b",
                     core_rdata_o, core_err_o, e.data, e.err);
          end
        end
      end else if (core_rvalid_o !== 1'b0 || core_rdata_o !== 32'h0) begin
        n_bad++;
        $display("FAIL resp_idle: rvalid=%b rdata=%h, required rvalid=0 rdata=0",
                 core_rvalid_o, core_rdata_o);
      end
    end
  end

  task automatic idle();
    core_req_i = 0; core_addr_i = 0; core_we_i = 0; core_be_i = 4'hF; core_wdata_i = 0;
    ram_gnt_i = 0; ram_rvalid_i = 0; ram_rdata_i = 0;
    peri_gnt_i = 0; peri_rvalid_i = 0; peri_rdata_i = 0;
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_exp(input logic [31:0] d, input logic e);
    exp_t x;
    x.data = d; x.err = e;
    exp_q.push_back(x);
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    core_req_i = 1; core_addr_i = 32'h8000_0000;
    @(negedge clk);
    n_cmp++;
    if ({core_gnt_o, ram_req_o, peri_req_o, core_rvalid_o, core_err_o, order_err_o} !== 6'b0 ||
        core_rdata_o !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: gnt=%b ram_req=%b peri_req=%b rvalid=%b err=%b oerr=%b rdata=%h, required all 0",
               core_gnt_o, ram_req_o, peri_req_o, core_rvalid_o, core_err_o, order_err_o, core_rdata_o);
    end
    idle();
    tick(); rst_n = 1;
    tick();
  endtask

  task automatic test_ram_read();
    core_req_i = 1; core_addr_i = 32'h0000_0010; ram_gnt_i = 1;
    @(negedge clk);
    n_cmp++;
    if (core_gnt_o !== 1 || ram_req_o !== 1 || peri_req_o !== 0 || ram_addr_o !== 32'h10) begin
      n_bad++;
      $display("FAIL ram_read_req: gnt=%b ram_req=%b peri_req=%b addr=%h, required 1 1 0 00000010",
               core_gnt_o, ram_req_o, peri_req_o, ram_addr_o);
    end
    push_exp(32'hDEADBEEF, 1'b0);
    tick();
    idle(); ram_rvalid_i = 1; ram_rdata_i = 32'hDEADBEEF;
    @(negedge clk);
    n_cmp++;
    if (core_rvalid_o !== 1 || order_err_o !== 0) begin
      n_bad++;
      $display("FAIL ram_read_resp: rvalid=%b oerr=%b, required 1 0", core_rvalid_o, order_err_o);
    end
    tick(); idle();
    tick();
  endtask

  task automatic test_peri_write_wait();
    core_req_i = 1; core_addr_i = 32'h1A10_0004; core_we_i = 1; core_wdata_i = 32'h5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (peri_req_o !== 1 || core_gnt_o !== 0 || ram_req_o !== 0 ||
          peri_write_o !== 1 || peri_wdata_o !== 32'h5) begin
        n_bad++;
        $display("FAIL peri_wait c%0d: peri_req=%b gnt=%b ram_req=%b we=%b wdata=%h, required 1 0 0 1 5",
                 i, peri_req_o, core_gnt_o, ram_req_o, peri_write_o, peri_wdata_o);
      end
      tick();
    end
    peri_gnt_i = 1;
    @(negedge clk);
    n_cmp++;
    if (core_gnt_o !== 1 || peri_req_o !== 1 || ram_req_o !== 0) begin
      n_bad++;
      $display("FAIL peri_grant: gnt=%b peri_req=%b ram_req=%b, required 1 1 0",
               core_gnt_o, peri_req_o, ram_req_o);
    end
    push_exp(32'h0, 1'b0);
    tick();
    idle(); peri_rvalid_i = 1;
    tick(); idle();
    tick();
  endtask

  task automatic test_err();
    core_req_i = 1; core_addr_i = 32'h8000_0000;
    @(negedge clk);
    n_cmp++;
    if (core_gnt_o !== 1 || ram_req_o !== 0 || peri_req_o !== 0 || core_rvalid_o !== 0) begin
      n_bad++;
      $display("FAIL err_grant: gnt=%b ram_req=%b peri_req=%b rvalid=%b, required 1 0 0 0",
               core_gnt_o, ram_req_o, peri_req_o, core_rvalid_o);
    end
    push_exp(32'h0, 1'b1);
    tick(); idle();
    @(negedge clk);
    n_cmp++;
    if (core_rvalid_o !== 1 || core_err_o !== 1 || core_rdata_o !== 0) begin
      n_bad++;
      $display("FAIL err_resp: rvalid=%b err=%b rdata=%h, required 1 1 0",
               core_rvalid_o, core_err_o, core_rdata_o);
    end
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    logic exp_gnt [6];
    exp_gnt = '{1, 1, 0, 0, 0, 1};
    core_req_i = 1; core_addr_i = 32'h0000_0100; ram_gnt_i = 1;
    for (int c = 0; c < 6; c++) begin
      ram_rvalid_i = (c == 4); ram_rdata_i = (c == 4) ? 32'hA000_0001 : 32'h0;
      @(negedge clk);
      n_cmp++;
      if (core_gnt_o !== exp_gnt[c] || ram_req_o !== exp_gnt[c]) begin
        n_bad++;
        $display("FAIL b2b c%0d: gnt=%b ram_req=%b, required %b", c, core_gnt_o, ram_req_o, exp_gnt[c]);
      end
      if (exp_gnt[c]) push_exp(32'hA000_0001 + (c == 0 ? 0 : (c == 1 ? 1 : 2)), 1'b0);
      tick();
    end
    idle(); ram_rvalid_i = 1; ram_rdata_i = 32'hA000_0002;
    tick(); ram_rdata_i = 32'hA000_0003;
    tick(); idle();
    tick();
  endtask

  task automatic test_switch_stall();
    core_req_i = 1; core_addr_i = 32'h0000_0200; ram_gnt_i = 1;
    @(negedge clk);
    if (core_gnt_o === 1'b1) push_exp(32'hB000_0001, 1'b0);
    tick();
    idle(); core_req_i = 1; core_addr_i = 32'h1A10_0008; peri_gnt_i = 1;
    for (int c = 0; c < 4; c++) begin
      ram_rvalid_i = (c == 2); ram_rdata_i = (c == 2) ? 32'hB000_0001 : 32'h0;
      @(negedge clk);
      n_cmp++;
      if (peri_req_o !== (c == 3) || core_gnt_o !== (c == 3) || ram_req_o !== 0) begin
        n_bad++;
        $display("FAIL switch_stall c%0d: peri_req=%b gnt=%b ram_req=%b, required %b %b 0",
                 c, peri_req_o, core_gnt_o, ram_req_o, c == 3, c == 3);
      end
      if (c == 3) push_exp(32'hC000_0001, 1'b0);
      tick();
    end
    idle(); peri_rvalid_i = 1; peri_rdata_i = 32'hC000_0001;
    tick(); idle();
    tick();
  endtask

  task automatic test_orphan();
    n_cmp++;
    if (order_err_o !== 0) begin
      n_bad++;
      $display("FAIL orphan_pre: order_err=%b, required 0", order_err_o);
    end
    peri_rvalid_i = 1; peri_rdata_i = 32'h1234_5678;
    tick(); idle();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if (order_err_o !== 1) begin
        n_bad++;
        $display("FAIL orphan_sticky c%0d: order_err=%b, required 1", c, order_err_o);
      end
      tick();
    end
    rst_n = 0;
    #1;
    n_cmp++;
    if (order_err_o !== 0) begin
      n_bad++;
      $display("FAIL orphan_clear: order_err=%b, required 0", order_err_o);
    end
    tick(); rst_n = 1;
    tick();
  endtask

  task automatic test_reset_mid();
    core_req_i = 1; core_addr_i = 32'h0000_0300; ram_gnt_i = 1;
    tick(); idle();
    rst_n = 0;
    exp_q.delete();
    tick(); rst_n = 1;
    tick();
    ram_rvalid_i = 1; ram_rdata_i = 32'hDEAD_0000;
    @(negedge clk);
    n_cmp++;
    if (core_rvalid_o !== 0) begin
      n_bad++;
      $display("FAIL reset_mid_drop: rvalid=%b, required 0", core_rvalid_o);
    end
    tick(); idle();
    @(negedge clk);
    n_cmp++;
    if (order_err_o !== 1) begin
      n_bad++;
      $display("FAIL reset_mid_oerr: order_err=%b, required 1", order_err_o);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_ram_read();
    test_peri_write_wait();
    test_err();
    test_back_to_back();
    test_switch_stall();
    test_orphan();
    test_reset_mid();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL resp_missing: %0d responses outstanding, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_bus_demux.md
DATA_BUS_DEMUX -- requirements
Module: data_bus_demux

Interface
REQ-001 Parameters SHALL be:
- RAM_BASE, default 32'h0000_0000, RAM region base.
- RAM_MASK, default 32'hFFF0_0000, RAM region decode mask.
- PERI_BASE, default 32'h1A10_0000, peripheral region base.
- PERI_MASK, default 32'hFFF0_0000, peripheral region decode mask.
- MAX_OUTST, default 2, outstanding-transaction limit (range 1..4).

REQ-002 Ports SHALL be:
- clk  in  1  single clock
- rst_n  in  1  reset, asynchronous, active-low
- core_req_i  in  1  core request
- core_addr_i  in  32  byte address
- core_we_i  in  1  write enable
- core_be_i  in  4  byte enables
- core_wdata_i  in  32  write data
- core_gnt_o  out  1  request accepted
- core_rvalid_o  out  1  response valid
- core_rdata_o  out  32  read data
- core_err_o  out  1  response error
- ram_req_o / ram_addr_o / ram_we_o / ram_be_o / ram_wdata_o  out  1/32/1/4/32  RAM request
- ram_gnt_i / ram_rvalid_i / ram_rdata_i  in  1/1/32  RAM handshake
- peri_req_o / peri_addr_o / peri_write_o / peri_be_o / peri_wdata_o  out  1/32/1/4/32  peripheral request (drives the peripheral block's peri_* inputs)
- peri_gnt_i / peri_rvalid_i / peri_rdata_i  in  1/1/32  peripheral handshake
- order_err_o  out  1  sticky protocol-violation flag

REQ-003 The block SHALL have one clock (clk) and an asynchronous, active-low reset (rst_n).

Function
REQ-004 Decode SHALL be combinational:
- RAM when (addr & RAM_MASK) == RAM_BASE.
- Otherwise PERI when (addr & PERI_MASK) == PERI_BASE.
- Otherwise ERR.

REQ-005 Addr, we, be and wdata SHALL pass unchanged to both target ports; only the selected target's req is asserted.

REQ-006 A request SHALL be forwarded only when it can be accepted; it is blocked (target req=0, core_gnt_o=0) when either holds:
- the tracking FIFO holds MAX_OUTST entries;
- the FIFO is non-empty and its tail target differs from the decoded target (target-switch stall).

REQ-007 core_gnt_o SHALL equal:
- the selected target's gnt, for RAM or PERI;
- 1 in the same cycle, for ERR.
In each case it is gated by REQ-006.

REQ-008 Every accepted request SHALL push its target ID (RAM/PERI/ERR) into the tracking FIFO in the grant cycle.

REQ-009 Responses SHALL be returned in order according to the FIFO head:
- Head RAM: core_rvalid_o=ram_rvalid_i, core_rdata_o=ram_rdata_i, core_err_o=0.
- Head PERI: same mapping from the peri_* response inputs, core_err_o=0.
- Head ERR: core_rvalid_o=1, core_rdata_o=0, core_err_o=1 in the first cycle the entry is head. Minimum latency is 1 cycle after grant.

REQ-010 A response SHALL pop the FIFO head in the cycle core_rvalid_o=1.

REQ-011 Push and pop in the same cycle SHALL leave the occupancy unchanged. A full FIFO with a simultaneous pop SHALL still block the new request, so the full check uses registered occupancy.

REQ-012 An rvalid from a target that is not the head, or any rvalid while the FIFO is empty, SHALL be dropped and SHALL set order_err_o, which stays 1 until reset.

REQ-013 With core_rvalid_o=0, core_rdata_o SHALL be 32'h0.

REQ-014 Occupancy SHALL never exceed MAX_OUTST or underflow; pointers wrap modulo MAX_OUTST.

Reset
REQ-015 On rst_n=0, asynchronously:
- FIFO empty, pointers 0.
- order_err_o=0.
- core_gnt_o, core_rvalid_o, core_err_o, ram_req_o and peri_req_o = 0.
- core_rdata_o = 0.

REQ-016 Reset asserted mid-transaction SHALL discard all outstanding entries. Responses arriving after reset release SHALL set order_err_o.

Structure
REQ-017 Package soc_bus_pkg SHALL hold:
- enum target_e {TGT_RAM, TGT_PERI, TGT_ERR} (2 bits);
- default base and mask constants.

REQ-018 The tracking FIFO SHALL be a sub-module bus_resp_fifo, parameterised by depth and entry width, with push, pop, full, empty and head outputs.

Verification
REQ-019 Read to 32'h0000_0010 with RAM gnt the same cycle and rvalid one cycle later with rdata 32'hDEADBEEF -> core_rvalid_o=1, core_rdata_o=32'hDEADBEEF, core_err_o=0, order_err_o=0.

REQ-020 Write to 32'h1A10_0004 with wdata 32'h5, peri_gnt_i held 0 for 3 cycles -> peri_req_o held, core_gnt_o=0 for 3 cycles, then gnt; ram_req_o=0 throughout.

REQ-021 Read to 32'h8000_0000 (unmapped) -> core_gnt_o=1 the same cycle; next cycle core_rvalid_o=1, core_err_o=1, core_rdata_o=0; no target req.

REQ-022 Back-to-back RAM reads with RAM rvalid withheld -> 2 grants, then the third request blocked until the first rvalid.

REQ-023 Outstanding RAM read followed by a PERI request -> PERI request stalled until the RAM response pops, then forwarded.

REQ-024 peri_rvalid_i pulse while the FIFO is empty -> no core_rvalid_o, order_err_o=1, and it remains 1 until rst_n=0.
